wb_regs_responder: RTL and testbench
====================================

// Module: wb_regs_responder
// PURPOSE
//  Synthesizable Wishbone slave. Implements the I2CMB register front end (CSR, DPR, CMDR, FSMR) and answers the WB master BFM's cycles.
//  Turns CMDR writes into a valid/ready command to the byte-level I2C controller and captures its responses.
//  Raises irq_o on completion; a CMDR read clears it.
// PARAMETERS
//  ADDR_WIDTH  2   WB address width; only the low 2 bits are decoded.
//  DATA_WIDTH  8   WB data width; fixed at 8, other values are an elaboration error.
//  NUM_BUSES   16  Number of selectable I2C buses; legal bus IDs are 0..NUM_BUSES-1.
// PORTS
//  clk_i        in   1           System clock.
//  rst_i        in   1           Asynchronous reset, active-low.
//  cyc_i        in   1           WB cycle.
//  stb_i        in   1           WB strobe.
//  we_i         in   1           WB write enable.
//  adr_i        in   ADDR_WIDTH  WB address: 0=CSR, 1=DPR, 2=CMDR, 3=FSMR.
//  dat_i        in   8           WB write data.
//  dat_o        out  8           WB read data.
//  ack_o        out  1           WB acknowledge.
//  irq_o        out  1           Interrupt, level-sensitive.
//  cmd_valid_o  out  1           Command to the controller is valid.
//  cmd_ready_i  in   1           Controller accepts the command.
//  cmd_code_o   out  3           Command code.
//  cmd_data_o   out  8           Byte for a WRITE command (DPR value).
//  rsp_valid_i  in   1           Controller response strobe, 1 cycle.
//  rsp_code_i   out/in 2 -> in  2 Response: 0=DONE, 1=NAK, 2=ARB_LOST, 3=ERR.
//  rsp_data_i   in   8           Byte received by a READ command.
//  bus_busy_i   in   1           Selected I2C bus is busy.
//  ctrl_state_i in   4           Controller FSM state, mirrored into FSMR[3:0].
//  bus_sel_o    out  4           Selected bus ID.
//  abort_o      out  1           1-cycle pulse when the core is disabled.
// BEHAVIOUR
//  Reset (rst_i=0): all registers 0, FSM=DISABLED. Outputs ack_o, irq_o, cmd_valid_o, abort_o = 0. dat_o, cmd_code_o, cmd_data_o = 0. bus_sel_o = 0.
//  WB handshake:
//   - cyc_i&stb_i&!ack_o -> ack_o=1 on the next clock, held for exactly 1 cycle.
//   - ack_o is never asserted on two consecutive cycles.
//   - Read data is valid in the same cycle as ack_o.
//   - Register side effects apply on the ack cycle.
//  CSR register:
//   - [7] E, [6] IE: read/write.
//   - [5] BB = bus_busy_i, read-only.
//   - [3:0] = bus_sel_o, read-only.
//   - Writing E 1->0: clears DPR and CMDR status, drops cmd_valid_o, pulses abort_o, FSM -> DISABLED.
//   - Writing E=1: FSM DISABLED -> IDLE.
//  DPR register:
//   - Write stores the byte for the next WRITE or SET_BUS.
//   - Read returns the last rsp_data_i captured on a READ DONE.
//  CMDR write, low 3 bits = command code (names and encodings in wb_types_pkg):
//   - 0 = WAIT, 1 = WRITE, 2 = READ with ACK, 3 = READ with NACK, 4 = START, 5 = STOP, 6 = SET_BUS.
//   - Write bits [2:0] hold the code. Ignored when E=0.
//  CMDR read:
//   - [7] DON, [6] NAK, [5] AL, [4] ERR, [2:0] last command code.
//   - Reading clears DON/NAK/AL/ERR on the ack cycle. The returned value is the pre-clear value.
//  FSMR register (read-only): [7:4] local FSM encoding, [3:0] = ctrl_state_i. Writes are ignored.
//  FSM states: DISABLED, IDLE, ISSUE, WAIT_RSP.
//   - IDLE + CMDR write of code 0..5 -> ISSUE. cmd_valid_o=1 with code/data held stable until cmd_ready_i.
//   - ISSUE + cmd_ready_i -> WAIT_RSP.
//   - WAIT_RSP + rsp_valid_i -> IDLE. Sets DON (DONE), NAK, AL or ERR from rsp_code_i.
//   - A READ with DONE loads DPR from rsp_data_i.
//  SET_BUS is handled locally, 1 cycle, no controller command:
//   - DPR < NUM_BUSES -> bus_sel_o = DPR[3:0], DON=1.
//   - Otherwise ERR=1, bus_sel_o unchanged.
//   - Rejected with ERR when bus_busy_i=1.
//  Code 7, or any CMDR write in ISSUE/WAIT_RSP: ERR=1. The in-flight command is unaffected.
//  irq_o = IE & (DON|NAK|AL|ERR), registered with 1-cycle latency.
//  Simultaneous events:
//   - rsp_valid_i on the same cycle as a CMDR-read ack: the clear applies first, then the new status. irq stays high.
//   - CSR write with E=0 on the same cycle as rsp_valid_i: the disable wins and the response is dropped.
//  rsp_valid_i in IDLE or DISABLED is ignored.
//  Reset asserted mid-transfer: immediate return to reset values. No abort_o pulse.
// STRUCTURE
//  Address map, CSR bit positions, command codes, response codes and the FSM state enum go in wb_types_pkg.
//  No sub-module needed. One always_ff each for the WB slave handshake, the register file and the FSM; combinational read mux.
// TESTING
//  1. Reset, then read CSR/DPR/CMDR -> all 0x00. irq_o=0. Each ack_o is 1 cycle, arriving 1 cycle after stb.
//  2. CSR=0xC0, DPR=0x05, CMDR=0x06 -> bus_sel_o=5, irq_o=1. CMDR read=0x86, then irq_o=0.
//  3. DPR=0x44, CMDR=0x01 -> cmd_valid_o held 3 cycles until cmd_ready_i, cmd_data_o=0x44.
//     Then rsp NAK -> CMDR read=0x41.
//  4. CMDR=0x02, rsp DONE with data 0xA5 -> DPR read=0xA5, CMDR read=0x82.
//  5. CMDR=0x04, then CMDR=0x05 before the response -> ERR set. Later rsp DONE -> CMDR read=0x94.
//  6. Command in WAIT_RSP, CSR=0x00 -> abort_o 1-cycle pulse, cmd_valid_o=0, FSMR[7:4]=DISABLED. The late rsp_valid_i is ignored.

Source files
------------

// File: rtl/wb_types_pkg.sv
// rtl/wb_types_pkg.sv - shared address map, bit positions, codes and FSM encoding for wb_regs_responder
package wb_types_pkg;

  // Register address map (low 2 address bits)
  localparam logic [1:0] ADR_CSR  = 2'd0;
  localparam logic [1:0] ADR_DPR  = 2'd1;
  localparam logic [1:0] ADR_CMDR = 2'd2;
  localparam logic [1:0] ADR_FSMR = 2'd3;

  // CSR bit positions
  localparam int CSR_E_BIT  = 7;
  localparam int CSR_IE_BIT = 6;
  localparam int CSR_BB_BIT = 5;

  typedef enum logic [2:0] {
    CMD_WAIT     = 3'd0,
    CMD_WRITE    = 3'd1,
    CMD_READ_ACK = 3'd2,
    CMD_READ_NAK = 3'd3,
    CMD_START    = 3'd4,
    CMD_STOP     = 3'd5,
    CMD_SET_BUS  = 3'd6,
    CMD_ILLEGAL  = 3'd7
  } cmd_code_e;

  typedef enum logic [1:0] {
    RSP_DONE     = 2'd0,
    RSP_NAK      = 2'd1,
    RSP_ARB_LOST = 2'd2,
    RSP_ERR      = 2'd3
  } rsp_code_e;

  typedef enum logic [1:0] {
    ST_DISABLED = 2'd0,
    ST_IDLE     = 2'd1,
    ST_ISSUE    = 2'd2,
    ST_WAIT_RSP = 2'd3
  } fsm_state_e;

  // Completion flags, ordered as they appear in CMDR[7:4]
  typedef struct packed {
    logic don;
    logic nak;
    logic al;
    logic err;
  } status_t;

endpackage

// File: rtl/wb_regs_responder_if.sv
// rtl/wb_regs_responder_if.sv - Wishbone slave bus bundle with master/slave views
interface wb_regs_responder_if #(
  parameter int ADDR_WIDTH = 2,
  parameter int DATA_WIDTH = 8
);
  logic                  cyc_i;
  logic                  stb_i;
  logic                  we_i;
  logic [ADDR_WIDTH-1:0] adr_i;
  logic [DATA_WIDTH-1:0] dat_i;
  logic [DATA_WIDTH-1:0] dat_o;
  logic                  ack_o;

  modport master (
    output cyc_i, stb_i, we_i, adr_i, dat_i,
    input  dat_o, ack_o
  );

  modport slave (
    input  cyc_i, stb_i, we_i, adr_i, dat_i,
    output dat_o, ack_o
  );
endinterface

// File: rtl/wb_regs_responder.sv
// rtl/wb_regs_responder.sv - I2CMB register front end: WB slave, command issue and response capture
module wb_regs_responder
  import wb_types_pkg::*;
#(
  parameter int ADDR_WIDTH = 2,
  parameter int DATA_WIDTH = 8,
  parameter int NUM_BUSES  = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  wb_regs_responder_if.slave        wb,
  output logic                      irq_o,
  output logic                      cmd_valid_o,
  input  logic                      cmd_ready_i,
  output logic [2:0]                cmd_code_o,
  output logic [7:0]                cmd_data_o,
  input  logic                      rsp_valid_i,
  input  logic [1:0]                rsp_code_i,
  input  logic [7:0]                rsp_data_i,
  input  logic                      bus_busy_i,
  input  logic [3:0]                ctrl_state_i,
  output logic [3:0]                bus_sel_o,
  output logic                      abort_o
);

  if (DATA_WIDTH != 8) begin : g_bad_data_width
    $error("wb_regs_responder: DATA_WIDTH must be 8");
  end
  if (ADDR_WIDTH < 2) begin : g_bad_addr_width
    $error("wb_regs_responder: ADDR_WIDTH must be at least 2");
  end

  localparam logic [8:0] NUM_BUSES_W = 9'(NUM_BUSES);

  logic       ack_q, ack_d;
  logic       csr_e_q, csr_e_d;
  logic       csr_ie_q, csr_ie_d;
  logic [7:0] dpr_q, dpr_d;
  status_t    stat_q, stat_d;
  logic [2:0] last_code_q, last_code_d;
  logic [3:0] bus_sel_q, bus_sel_d;
  logic       irq_q, irq_d;
  logic       abort_q, abort_d;
  fsm_state_e state_q, state_d;
  logic [2:0] cmd_code_q, cmd_code_d;
  logic [7:0] cmd_data_q, cmd_data_d;

  logic       acc, wr_en, rd_en;
  logic       csr_wr, dpr_wr, cmdr_wr, cmdr_rd;
  logic       disable_ev, rsp_take;
  logic [1:0] adr;
  cmd_code_e  wr_code;
  logic [7:0] rd_data;

  // Side effects land on the ack cycle while the master still holds the request
  assign adr        = wb.adr_i[1:0];
  assign acc        = ack_q & wb.cyc_i & wb.stb_i;
  assign wr_en      = acc & wb.we_i;
  assign rd_en      = acc & ~wb.we_i;
  assign csr_wr     = wr_en & (adr == ADR_CSR);
  assign dpr_wr     = wr_en & (adr == ADR_DPR);
  assign cmdr_wr    = wr_en & (adr == ADR_CMDR);
  assign cmdr_rd    = rd_en & (adr == ADR_CMDR);
  assign disable_ev = csr_wr & ~wb.dat_i[CSR_E_BIT] & csr_e_q;
  assign rsp_take   = rsp_valid_i & (state_q == ST_WAIT_RSP) & ~disable_ev;
  assign wr_code    = cmd_code_e'(wb.dat_i[2:0]);

  // Single-cycle ack, never back to back
  always_comb begin
    ack_d = wb.cyc_i & wb.stb_i & ~ack_q;
  end

  // Next-state for registers and command FSM; later assignments take priority
  always_comb begin
    csr_e_d     = csr_e_q;
    csr_ie_d    = csr_ie_q;
    dpr_d       = dpr_q;
    stat_d      = stat_q;
    last_code_d = last_code_q;
    bus_sel_d   = bus_sel_q;
    state_d     = state_q;
    cmd_code_d  = cmd_code_q;
    cmd_data_d  = cmd_data_q;
    abort_d     = 1'b0;
    irq_d       = csr_ie_q & (|stat_q);

    if (cmdr_rd) stat_d = '0;
    if (dpr_wr) dpr_d = wb.dat_i;

    case (state_q)
      ST_ISSUE: if (cmd_ready_i) state_d = ST_WAIT_RSP;
      ST_WAIT_RSP: begin
        if (rsp_take) begin
          state_d = ST_IDLE;
          case (rsp_code_i)
            RSP_DONE: begin
              stat_d.don = 1'b1;
              if (cmd_code_q == CMD_READ_ACK || cmd_code_q == CMD_READ_NAK) dpr_d = rsp_data_i;
            end
            RSP_NAK:      stat_d.nak = 1'b1;
            RSP_ARB_LOST: stat_d.al  = 1'b1;
            default:      stat_d.err = 1'b1;
          endcase
        end
      end
      default: ;
    endcase

    if (cmdr_wr && csr_e_q) begin
      if (state_q == ST_IDLE) begin
        last_code_d = wr_code;
        case (wr_code)
          CMD_SET_BUS: begin
            if (bus_busy_i || ({1'b0, dpr_q} >= NUM_BUSES_W)) begin
              stat_d.err = 1'b1;
            end else begin
              bus_sel_d  = dpr_q[3:0];
              stat_d.don = 1'b1;
            end
          end
          CMD_ILLEGAL: stat_d.err = 1'b1;
          default: begin
            state_d    = ST_ISSUE;
            cmd_code_d = wr_code;
            cmd_data_d = dpr_q;
          end
        endcase
      end else begin
        stat_d.err = 1'b1;
      end
    end

    if (csr_wr) begin
      csr_e_d  = wb.dat_i[CSR_E_BIT];
      csr_ie_d = wb.dat_i[CSR_IE_BIT];
      if (wb.dat_i[CSR_E_BIT] && state_q == ST_DISABLED) state_d = ST_IDLE;
    end

    if (disable_ev) begin
      dpr_d   = '0;
      stat_d  = '0;
      state_d = ST_DISABLED;
      abort_d = 1'b1;
    end
  end

  // Read mux, driven only while acking a read
  always_comb begin
    rd_data = '0;
    case (adr)
      ADR_CSR:  rd_data = {csr_e_q, csr_ie_q, bus_busy_i, 1'b0, bus_sel_q};
      ADR_DPR:  rd_data = dpr_q;
      ADR_CMDR: rd_data = {stat_q, 1'b0, last_code_q};
      default:  rd_data = {2'b00, state_q, ctrl_state_i};
    endcase
  end

  assign wb.dat_o    = rd_en ? rd_data : 8'h00;
  assign wb.ack_o    = ack_q;
  assign irq_o       = irq_q;
  assign abort_o     = abort_q;
  assign bus_sel_o   = bus_sel_q;
  assign cmd_valid_o = (state_q == ST_ISSUE);
  assign cmd_code_o  = cmd_code_q;
  assign cmd_data_o  = cmd_data_q;

  // WB handshake register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) ack_q <= 1'b0;
    else        ack_q <= ack_d;
  end

  // Register file
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      csr_e_q     <= 1'b0;
      csr_ie_q    <= 1'b0;
      dpr_q       <= '0;
      stat_q      <= '0;
      last_code_q <= '0;
      bus_sel_q   <= '0;
      irq_q       <= 1'b0;
      abort_q     <= 1'b0;
    end else begin
      csr_e_q     <= csr_e_d;
      csr_ie_q    <= csr_ie_d;
      dpr_q       <= dpr_d;
      stat_q      <= stat_d;
      last_code_q <= last_code_d;
      bus_sel_q   <= bus_sel_d;
      irq_q       <= irq_d;
      abort_q     <= abort_d;
    end
  end

  // Command FSM state and held command payload
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= ST_DISABLED;
      cmd_code_q <= '0;
      cmd_data_q <= '0;
    end else begin
      state_q    <= state_d;
      cmd_code_q <= cmd_code_d;
      cmd_data_q <= cmd_data_d;
    end
  end

endmodule

// File: tb/tb_wb_regs_responder.sv
// tb/tb_wb_regs_responder.sv - self-checking bench for wb_regs_responder
module tb_wb_regs_responder;
  import wb_types_pkg::*;

  logic       clk, rst_n;
  logic       irq, cmd_valid, cmd_ready, rsp_valid, bus_busy, abort;
  logic [2:0] cmd_code;
  logic [7:0] cmd_data, rsp_data;
  logic [1:0] rsp_code;
  logic [3:0] ctrl_state, bus_sel;

  int n_checks = 0;
  int n_fail   = 0;

  wb_regs_responder_if #(.ADDR_WIDTH(2), .DATA_WIDTH(8)) bus ();

  wb_regs_responder #(.ADDR_WIDTH(2), .DATA_WIDTH(8), .NUM_BUSES(16)) dut (
    .clk_i        (clk),
    .rst_i        (rst_n),
    .wb           (bus),
    .irq_o        (irq),
    .cmd_valid_o  (cmd_valid),
    .cmd_ready_i  (cmd_ready),
    .cmd_code_o   (cmd_code),
    .cmd_data_o   (cmd_data),
    .rsp_valid_i  (rsp_valid),
    .rsp_code_i   (rsp_code),
    .rsp_data_i   (rsp_data),
    .bus_busy_i   (bus_busy),
    .ctrl_state_i (ctrl_state),
    .bus_sel_o    (bus_sel),
    .abort_o      (abort)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit         we;
    logic [1:0] adr;
    logic [7:0] wd;
    logic [7:0] exp;
    logic [3:0] exp_bus;
    bit         busy;
  } vec_t;

  typedef struct {
    logic [2:0] code;
    logic [7:0] data;
  } cmd_t;

  vec_t       tbl[$];
  logic [7:0] rd_q[$];
  cmd_t       cmd_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic add(input bit we, input logic [1:0] adr, input logic [7:0] wd,
                     input logic [7:0] exp, input logic [3:0] exp_bus, input bit busy);
    vec_t v;
    v.we = we; v.adr = adr; v.wd = wd; v.exp = exp; v.exp_bus = exp_bus; v.busy = busy;
    tbl.push_back(v);
  endtask

  // One WB cycle; optional rsp_valid pulse lands on the ack (side-effect) edge
  task automatic wb_xfer(input bit we, input logic [1:0] adr, input logic [7:0] wd,
                         input logic [7:0] exp, input bit pulse);
    int n;
    logic [7:0] want;
    @(posedge clk); #1;
    bus.cyc_i = 1'b1; bus.stb_i = 1'b1; bus.we_i = we; bus.adr_i = adr; bus.dat_i = wd;
    if (!we) rd_q.push_back(exp);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!bus.ack_o && n < 8);
    chk("ack_latency", 32'(n), 32'd1);
    if (!we) begin
      want = rd_q.pop_front();
      if (bus.ack_o) chk("read_data", 32'(bus.dat_o), 32'(want));
    end
    if (pulse) rsp_valid = 1'b1;
    @(posedge clk); #1;
    rsp_valid = 1'b0;
    bus.cyc_i = 1'b0; bus.stb_i = 1'b0; bus.we_i = 1'b0;
    chk("ack_single_cycle", 32'(bus.ack_o), 32'd0);
  endtask

  task automatic run_vec(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      bus_busy = tbl[i].busy;
      wb_xfer(tbl[i].we, tbl[i].adr, tbl[i].wd, tbl[i].exp, 1'b0);
      chk($sformatf("bus_sel_v%0d", i), 32'(bus_sel), 32'(tbl[i].exp_bus));
    end
    bus_busy = 1'b0;
  endtask

  // Controller side: hold off ready for 'hold' cycles, then accept and check payload
  task automatic ctrl_accept(input int hold);
    cmd_t e;
    for (int i = 0; i < hold; i++) begin
      chk("cmd_valid_hold", 32'(cmd_valid), 32'd1);
      @(posedge clk); #1;
    end
    chk("cmd_valid", 32'(cmd_valid), 32'd1);
    if (cmd_q.size() == 0) begin
      chk("cmd_expected", 32'd0, 32'd1);
    end else begin
      e = cmd_q.pop_front();
      chk("cmd_code", 32'(cmd_code), 32'(e.code));
      chk("cmd_data", 32'(cmd_data), 32'(e.data));
    end
    cmd_ready = 1'b1;
    @(posedge clk); #1;
    cmd_ready = 1'b0;
    chk("cmd_valid_drop", 32'(cmd_valid), 32'd0);
  endtask

  task automatic rsp_pulse(input logic [1:0] code, input logic [7:0] data);
    rsp_code = code; rsp_data = data; rsp_valid = 1'b1;
    @(posedge clk); #1;
    rsp_valid = 1'b0;
  endtask

  task automatic push_cmd(input logic [2:0] code, input logic [7:0] data);
    cmd_t c;
    c.code = code; c.data = data;
    cmd_q.push_back(c);
  endtask

  initial begin
    rst_n = 1'b0; cmd_ready = 1'b0; rsp_valid = 1'b0; rsp_code = 2'd0; rsp_data = 8'h00;
    bus_busy = 1'b0; ctrl_state = 4'h9;
    bus.cyc_i = 1'b0; bus.stb_i = 1'b0; bus.we_i = 1'b0; bus.adr_i = 2'd0; bus.dat_i = 8'h00;

    //      we  adr       wd     exp    bus   busy
    add(1'b0, ADR_CSR,  8'h00, 8'h00, 4'h0, 1'b0);  // 0
    add(1'b0, ADR_DPR,  8'h00, 8'h00, 4'h0, 1'b0);  // 1
    add(1'b0, ADR_CMDR, 8'h00, 8'h00, 4'h0, 1'b0);  // 2
    add(1'b0, ADR_FSMR, 8'h00, 8'h09, 4'h0, 1'b0);  // 3
    add(1'b1, ADR_CSR,  8'hC0, 8'h00, 4'h0, 1'b0);  // 4
    add(1'b0, ADR_CSR,  8'h00, 8'hC0, 4'h0, 1'b0);  // 5
    add(1'b0, ADR_FSMR, 8'h00, 8'h19, 4'h0, 1'b0);  // 6
    add(1'b1, ADR_DPR,  8'h05, 8'h00, 4'h0, 1'b0);  // 7
    add(1'b1, ADR_CMDR, 8'h06, 8'h00, 4'h5, 1'b0);  // 8
    add(1'b0, ADR_CMDR, 8'h00, 8'h86, 4'h5, 1'b0);  // 9
    add(1'b0, ADR_CMDR, 8'h00, 8'h06, 4'h5, 1'b0);  // 10
    add(1'b1, ADR_DPR,  8'h10, 8'h00, 4'h5, 1'b0);  // 11
    add(1'b1, ADR_CMDR, 8'h06, 8'h00, 4'h5, 1'b0);  // 12
    add(1'b0, ADR_CMDR, 8'h00, 8'h16, 4'h5, 1'b0);  // 13
    add(1'b1, ADR_DPR,  8'h0F, 8'h00, 4'h5, 1'b0);  // 14
    add(1'b1, ADR_CMDR, 8'h06, 8'h00, 4'hF, 1'b0);  // 15
    add(1'b0, ADR_CMDR, 8'h00, 8'h86, 4'hF, 1'b0);  // 16
    add(1'b0, ADR_CSR,  8'h00, 8'hEF, 4'hF, 1'b1);  // 17
    add(1'b1, ADR_DPR,  8'h03, 8'h00, 4'hF, 1'b1);  // 18
    add(1'b1, ADR_CMDR, 8'h06, 8'h00, 4'hF, 1'b1);  // 19
    add(1'b0, ADR_CMDR, 8'h00, 8'h16, 4'hF, 1'b0);  // 20
    add(1'b1, ADR_CMDR, 8'h07, 8'h00, 4'hF, 1'b0);  // 21
    add(1'b0, ADR_CMDR, 8'h00, 8'h17, 4'hF, 1'b0);  // 22

    // Reset state
    idle(2);
    chk("rst_ack", 32'(bus.ack_o), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_cmd_valid", 32'(cmd_valid), 32'd0);
    chk("rst_abort", 32'(abort), 32'd0);
    chk("rst_bus_sel", 32'(bus_sel), 32'd0);
    chk("rst_cmd_code", 32'(cmd_code), 32'd0);
    chk("rst_cmd_data", 32'(cmd_data), 32'd0);
    chk("rst_dat_o", 32'(bus.dat_o), 32'd0);
    rst_n = 1'b1;

    // Register reads after reset, enable, SET_BUS and its corner cases
    run_vec(0, 8);
    idle(1);
    chk("irq_after_set_bus", 32'(irq), 32'd1);
    run_vec(9, 10);
    idle(1);
    chk("irq_after_cmdr_read", 32'(irq), 32'd0);
    run_vec(11, 22);

    // WRITE held off three cycles, NAK response
    wb_xfer(1'b1, ADR_DPR, 8'h44, 8'h00, 1'b0);
    push_cmd(CMD_WRITE, 8'h44);
    wb_xfer(1'b1, ADR_CMDR, 8'h01, 8'h00, 1'b0);
    ctrl_accept(2);
    rsp_pulse(RSP_NAK, 8'h00);
    idle(1);
    chk("irq_after_nak", 32'(irq), 32'd1);
    wb_xfer(1'b0, ADR_CMDR, 8'h00, 8'h41, 1'b0);

    // READ with DONE loads DPR
    push_cmd(CMD_READ_ACK, 8'h44);
    wb_xfer(1'b1, ADR_CMDR, 8'h02, 8'h00, 1'b0);
    ctrl_accept(0);
    rsp_pulse(RSP_DONE, 8'hA5);
    wb_xfer(1'b0, ADR_DPR,  8'h00, 8'hA5, 1'b0);
    wb_xfer(1'b0, ADR_CMDR, 8'h00, 8'h82, 1'b0);

    // CMDR write while a command is in flight
    push_cmd(CMD_START, 8'hA5);
    wb_xfer(1'b1, ADR_CMDR, 8'h04, 8'h00, 1'b0);
    ctrl_accept(0);
    wb_xfer(1'b1, ADR_CMDR, 8'h05, 8'h00, 1'b0);
    chk("busy_write_no_issue", 32'(cmd_valid), 32'd0);
    rsp_pulse(RSP_DONE, 8'h00);
    wb_xfer(1'b0, ADR_CMDR, 8'h00, 8'h94, 1'b0);

    // Response on the same edge as a CMDR read clear
    push_cmd(CMD_STOP, 8'hA5);
    wb_xfer(1'b1, ADR_CMDR, 8'h05, 8'h00, 1'b0);
    ctrl_accept(0);
    wb_xfer(1'b1, ADR_CMDR, 8'h03, 8'h00, 1'b0);
    idle(1);
    chk("irq_err_pending", 32'(irq), 32'd1);
    rsp_code = RSP_DONE; rsp_data = 8'h00;
    wb_xfer(1'b0, ADR_CMDR, 8'h00, 8'h15, 1'b1);
    chk("irq_hold_0", 32'(irq), 32'd1);
    idle(1);
    chk("irq_hold_1", 32'(irq), 32'd1);
    wb_xfer(1'b0, ADR_CMDR, 8'h00, 8'h85, 1'b0);

    // Disable in WAIT_RSP, coincident and late responses dropped
    push_cmd(CMD_WRITE, 8'hA5);
    wb_xfer(1'b1, ADR_CMDR, 8'h01, 8'h00, 1'b0);
    ctrl_accept(0);
    rsp_code = RSP_DONE; rsp_data = 8'h00;
    wb_xfer(1'b1, ADR_CSR, 8'h00, 8'h00, 1'b1);
    chk("abort_pulse", 32'(abort), 32'd1);
    chk("disable_cmd_valid", 32'(cmd_valid), 32'd0);
    idle(1);
    chk("abort_one_cycle", 32'(abort), 32'd0);
    rsp_pulse(RSP_DONE, 8'h77);
    wb_xfer(1'b0, ADR_FSMR, 8'h00, 8'h09, 1'b0);
    wb_xfer(1'b0, ADR_CMDR, 8'h00, 8'h01, 1'b0);
    wb_xfer(1'b0, ADR_DPR,  8'h00, 8'h00, 1'b0);
    chk("irq_disabled", 32'(irq), 32'd0);

    // CMDR ignored while disabled
    wb_xfer(1'b1, ADR_CMDR, 8'h01, 8'h00, 1'b0);
    chk("disabled_cmdr_ignored", 32'(cmd_valid), 32'd0);
    wb_xfer(1'b0, ADR_FSMR, 8'h00, 8'h09, 1'b0);

    // Reset mid-transfer
    wb_xfer(1'b1, ADR_CSR,  8'h80, 8'h00, 1'b0);
    wb_xfer(1'b1, ADR_DPR,  8'h22, 8'h00, 1'b0);
    wb_xfer(1'b1, ADR_CMDR, 8'h01, 8'h00, 1'b0);
    chk("pre_reset_cmd_valid", 32'(cmd_valid), 32'd1);
    chk("pre_reset_cmd_data", 32'(cmd_data), 32'h22);
    rst_n = 1'b0;
    #2;
    chk("midrst_cmd_valid", 32'(cmd_valid), 32'd0);
    chk("midrst_cmd_data", 32'(cmd_data), 32'd0);
    chk("midrst_bus_sel", 32'(bus_sel), 32'd0);
    chk("midrst_abort", 32'(abort), 32'd0);
    idle(1);
    chk("midrst_abort_later", 32'(abort), 32'd0);
    rst_n = 1'b1;
    wb_xfer(1'b0, ADR_CSR, 8'h00, 8'h00, 1'b0);

    chk("cmd_scoreboard_empty", 32'(cmd_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
